lsu_wb: RTL and testbench
=========================

Name: lsu_wb

Overview:
- Load/store + writeback stage sitting directly upstream of the register file; produces its rd / we / wdata write port.
- Accepts one memory op at a time from execute via a valid/ready handshake.
- Drives a data-memory request/response interface; aligns and sign/zero-extends load data.
- Issues a single-cycle register write; stores complete without writeback.

Parameters:
ADDR_W, 32, width of addr / mem_addr.
MAX_OUTSTANDING, 1, fixed at 1 (one op in flight); other values are illegal and caught by a static assertion.

Ports:
clk  in  1  clock, all state changes on posedge
reset_n  in  1  asynchronous active-low reset
req_valid  in  1  execute presents an op
req_ready  out  1  stage can accept (high only in IDLE)
req_is_store  in  1  1=store, 0=load
req_funct3  in  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data, low-aligned
req_rd  in  5  load destination
mem_valid  out  1  memory request valid
mem_ready  in  1  memory accepts request
mem_addr  out  ADDR_W  word address, bits [1:0] = 0
mem_wstrb  out  4  byte strobes; 0000 for load
mem_wdata  out  32  store data shifted into byte lanes
mem_rvalid  in  1  load response valid
mem_rdata  in  32  load response word
wb_we  out  1  register write enable, one-cycle pulse
wb_rd  out  5  register index
wb_wdata  out  32  extended load value
busy  out  1  high in any state other than IDLE
err  out  1  misaligned-access pulse; see Optional Feature

Behaviour:
- Reset (async, reset_n=0): state IDLE; mem_valid, wb_we, err, busy = 0; mem_addr, mem_wstrb, mem_wdata, wb_rd, wb_wdata = 0.
- FSM: IDLE -> REQ -> (store: IDLE | load: WAIT -> WB -> IDLE).
- IDLE: req_ready=1. On req_valid, latch addr, funct3, wdata, rd, is_store; go to REQ.
- REQ: mem_valid=1 with stable mem_addr/wstrb/wdata until mem_ready. On mem_valid&mem_ready: store -> IDLE; load -> WAIT.
- WAIT: on mem_rvalid, capture the extended lane data; go to WB.
- WB: wb_we=1 for exactly one cycle, except when rd==0 (wb_we=0; state still passes through WB). Then IDLE.
- mem_rvalid outside WAIT is ignored, including a stray response after reset.
- Minimum load latency is 4 cycles from accept to wb_we (accept, REQ with mem_ready=1, WAIT with rvalid=1, WB). Minimum store occupancy is 2 cycles.
- Lane select uses addr[1:0]:
  - B/BU: byte addr[1:0]; strobe 0001<<addr[1:0].
  - H/HU: half addr[1]; strobe 0011<<(2*addr[1]).
  - W: strobe 1111.
- B/H sign-extend; BU/HU zero-extend. Store with funct3 BU/HU/other is illegal: treated as W.
- Unknown load funct3 (011, 110, 111) is treated as W.
- Without the optional feature, misaligned low bits are ignored: H uses addr[1] only, W forces lane 0.
- wb_rd/wb_wdata hold their last value after the WB pulse.
- Reset mid-operation aborts immediately: no wb_we, mem_valid drops asynchronously.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: in IDLE, a request with H and addr[0]=1, or W and addr[1:0]!=0, is accepted but no memory request is made. err pulses 1 for one cycle in the cycle after accept, then IDLE; no wb_we.
- Not defined: err is tied to 0 and the alignment-ignoring rule above applies.

Decomposition:
- Shared package rv_pkg: funct3 load/store width constants (F3_B, F3_H, F3_W, F3_BU, F3_HU) and the lsu_state_e enum (IDLE, REQ, WAIT, WB). Reusable by the decoder and testbench.
- One sub-module: lsu_align, purely combinational, holding store lane shift + strobe generation and load extract + extend.

Test Plan:
- LW x5, addr 0x100; mem_ready=1; rvalid next cycle with rdata 0xDEADBEEF -> wb_we one cycle, wb_rd=5, wb_wdata=0xDEADBEEF, 4 cycles from accept.
- LB x6, addr 0x103, rdata 0x80112233 -> mem_addr 0x100, wb_wdata 0xFFFFFF80. LBU same -> 0x00000080. LHU at 0x102 -> 0x00008011.
- SB addr 0x101, wdata 0xAB -> mem_wstrb 0010, mem_wdata[15:8]=0xAB. Hold mem_ready=0 for 3 cycles -> mem_valid and outputs stable. No wb_we.
- LW with rd=0 -> memory access occurs, wb_we stays 0, busy returns low after WB.
- Assert reset_n=0 in WAIT -> mem_valid/busy 0 immediately. A later rvalid produces no wb_we. Next request proceeds normally.
- With LSU_MISALIGN_TRAP_EN: LW at 0x102 -> mem_valid never asserts, err=1 for one cycle, no wb_we. Without the macro: same op reads word 0x100.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared RV32I load/store width codes and LSU state encoding.
// Used by lsu_wb, lsu_align and any decoder that needs the funct3 widths.
package rv_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        WB
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } lsu_size_e;

    // Stores only honour B and H; every other store code (and unknown load codes) is a word.
    function automatic lsu_size_e access_size(input logic [2:0] funct3, input logic is_store);
        lsu_size_e size;
        size = SZ_WORD;
        if (is_store) begin
            if (funct3 == F3_B) begin
                size = SZ_BYTE;
            end else if (funct3 == F3_H) begin
                size = SZ_HALF;
            end
        end else begin
            case (funct3)
                F3_B, F3_BU: size = SZ_BYTE;
                F3_H, F3_HU: size = SZ_HALF;
                default:     size = SZ_WORD;
            endcase
        end
        return size;
    endfunction

    function automatic logic is_misaligned(input lsu_size_e size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SZ_HALF: bad = addr_lo[0];
            SZ_WORD: bad = (addr_lo != 2'b00);
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: store lane placement and strobes, load extract and extend.
// Half accesses look only at addr[1]; word accesses always use lane 0.
module lsu_align
    import rv_pkg::*;
(
    input  logic        i_is_store,
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_store_data,
    input  logic [31:0] i_load_word,
    output logic [3:0]  o_wstrb,
    output logic [31:0] o_store_lanes,
    output logic [31:0] o_load_value
);

    lsu_size_e   w_size;
    logic [31:0] w_shifted;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_signed;

    assign w_size    = access_size(i_funct3, i_is_store);
    assign w_shifted = i_load_word >> {i_addr_lo, 3'b000};
    assign w_byte    = w_shifted[7:0];
    assign w_half    = i_addr_lo[1] ? i_load_word[31:16] : i_load_word[15:0];
    assign w_signed  = (i_funct3 == F3_B) || (i_funct3 == F3_H);

    // Narrow store data is replicated across lanes; the strobe picks the live one.
    always_comb begin
        o_wstrb       = 4'b1111;
        o_store_lanes = i_store_data;
        case (w_size)
            SZ_BYTE: begin
                o_wstrb       = 4'b0001 << i_addr_lo;
                o_store_lanes = {4{i_store_data[7:0]}};
            end
            SZ_HALF: begin
                o_wstrb       = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_store_lanes = {2{i_store_data[15:0]}};
            end
            default: begin
                o_wstrb       = 4'b1111;
                o_store_lanes = i_store_data;
            end
        endcase
    end

    always_comb begin
        o_load_value = i_load_word;
        case (w_size)
            SZ_BYTE: o_load_value = {{24{w_signed & w_byte[7]}}, w_byte};
            SZ_HALF: o_load_value = {{16{w_signed & w_half[15]}}, w_half};
            default: o_load_value = i_load_word;
        endcase
    end

endmodule

// File: rtl/lsu_wb.sv
// Load/store + writeback stage: one op in flight, drives data memory and the regfile write port.
// Optional LSU_MISALIGN_TRAP_EN: misaligned H/W requests raise a one-cycle err instead of accessing.
module lsu_wb
    import rv_pkg::*;
#(
    parameter int unsigned ADDR_W          = 32,
    parameter int unsigned MAX_OUTSTANDING = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_is_store,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [4:0]        req_rd,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_wstrb,
    output logic [31:0]       mem_wdata,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    output logic              wb_we,
    output logic [4:0]        wb_rd,
    output logic [31:0]       wb_wdata,
    output logic              busy,
    output logic              err
);

    if (MAX_OUTSTANDING != 1) begin : g_bad_outstanding
        $error("lsu_wb: MAX_OUTSTANDING must be 1");
    end
    if (ADDR_W < 3) begin : g_bad_addr_w
        $error("lsu_wb: ADDR_W must be at least 3");
    end

    lsu_state_e        r_state;
    lsu_state_e        w_next_state;
    logic              r_is_store;
    logic [2:0]        r_funct3;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [4:0]        r_rd;
    logic [4:0]        r_wb_rd;
    logic [31:0]       r_wb_wdata;

    logic              w_accept;
    logic              w_trap;
    logic [3:0]        w_wstrb;
    logic [31:0]       w_store_lanes;
    logic [31:0]       w_load_value;

    assign w_accept = req_valid && (r_state == IDLE);

`ifdef LSU_MISALIGN_TRAP_EN
    logic r_err;

    assign w_trap = w_accept &&
                    is_misaligned(access_size(req_funct3, req_is_store), req_addr[1:0]);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_trap;
        end
    end

    assign err = r_err;
`else
    assign w_trap = 1'b0;
    assign err    = 1'b0;
`endif

    lsu_align u_align (
        .i_is_store    (r_is_store),
        .i_funct3      (r_funct3),
        .i_addr_lo     (r_addr[1:0]),
        .i_store_data  (r_wdata),
        .i_load_word   (mem_rdata),
        .o_wstrb       (w_wstrb),
        .o_store_lanes (w_store_lanes),
        .o_load_value  (w_load_value)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: if (w_accept && !w_trap) w_next_state = REQ;
            REQ:  if (mem_ready)           w_next_state = r_is_store ? IDLE : WAIT;
            WAIT: if (mem_rvalid)          w_next_state = WB;
            WB:                            w_next_state = IDLE;
            default:                       w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_is_store <= 1'b0;
            r_funct3   <= 3'b000;
            r_addr     <= '0;
            r_wdata    <= 32'h0;
            r_rd       <= 5'd0;
        end else if (w_accept && !w_trap) begin
            r_is_store <= req_is_store;
            r_funct3   <= req_funct3;
            r_addr     <= req_addr;
            r_wdata    <= req_wdata;
            r_rd       <= req_rd;
        end
    end

    // Writeback value is captured on the response so mem_rdata need not be held.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wb_rd    <= 5'd0;
            r_wb_wdata <= 32'h0;
        end else if ((r_state == WAIT) && mem_rvalid) begin
            r_wb_rd    <= r_rd;
            r_wb_wdata <= w_load_value;
        end
    end

    always_comb begin
        req_ready = (r_state == IDLE);
        mem_valid = (r_state == REQ);
        busy      = (r_state != IDLE);
        wb_we     = (r_state == WB) && (r_wb_rd != 5'd0);
        mem_addr  = {r_addr[ADDR_W-1:2], 2'b00};
        mem_wstrb = r_is_store ? w_wstrb : 4'b0000;
        mem_wdata = r_is_store ? w_store_lanes : 32'h0;
        wb_rd     = r_wb_rd;
        wb_wdata  = r_wb_wdata;
    end

endmodule

// File: tb/tb_lsu_wb.sv
// Self-checking bench for lsu_wb: directed cases plus randomized ops against a behavioural model.
// Honours LSU_MISALIGN_TRAP_EN when the macro is defined for the build.
module tb_lsu_wb;
    import rv_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_wdata;
    logic        busy;
    logic        err;

    int checks   = 0;
    int failures = 0;

    lsu_wb #(
        .ADDR_W          (32),
        .MAX_OUTSTANDING (1)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_is_store (req_is_store),
        .req_funct3   (req_funct3),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_rd       (req_rd),
        .mem_valid    (mem_valid),
        .mem_ready    (mem_ready),
        .mem_addr     (mem_addr),
        .mem_wstrb    (mem_wstrb),
        .mem_wdata    (mem_wdata),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata),
        .wb_we        (wb_we),
        .wb_rd        (wb_rd),
        .wb_wdata     (wb_wdata),
        .busy         (busy),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Reference model: plain arithmetic on the RV32I width rules.
    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                               input logic [31:0] word);
        logic [31:0] b;
        logic [31:0] h;
        b = (word >> (8 * addr[1:0])) & 32'hff;
        h = (word >> (16 * addr[1])) & 32'hffff;
        case (f3)
            3'b000:  return (b >= 32'd128) ? (b | 32'hffffff00) : b;
            3'b100:  return b;
            3'b001:  return (h >= 32'd32768) ? (h | 32'hffff0000) : h;
            3'b101:  return h;
            default: return word;
        endcase
    endfunction

    function automatic logic [3:0] model_strb(input logic [2:0] f3, input logic [31:0] addr);
        case (f3)
            3'b000:  return 4'(1 << addr[1:0]);
            3'b001:  return addr[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] model_lanes(input logic [2:0] f3, input logic [31:0] addr,
                                                input logic [31:0] wdata);
        case (f3)
            3'b000:  return (wdata & 32'hff) << (8 * addr[1:0]);
            3'b001:  return (wdata & 32'hffff) << (16 * addr[1]);
            default: return wdata;
        endcase
    endfunction

    function automatic logic [31:0] strb_mask(input logic [3:0] strb);
        logic [31:0] m;
        m = 32'h0;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) m = m | (32'hff << (8 * i));
        end
        return m;
    endfunction

    function automatic bit model_misaligned(input bit st, input logic [2:0] f3,
                                            input logic [31:0] addr);
        bit half;
        bit byte_op;
        byte_op = st ? (f3 == 3'b000) : (f3 == 3'b000 || f3 == 3'b100);
        half    = st ? (f3 == 3'b001) : (f3 == 3'b001 || f3 == 3'b101);
        if (byte_op) return 1'b0;
        if (half) return addr[0];
        return addr[1:0] != 2'b00;
    endfunction

    // Called on a negedge with the stage idle; returns on a negedge with the stage idle.
    task automatic do_op(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [4:0] rd, input int rdly,
                         input int vdly, input logic [31:0] rdata);
        logic [3:0]  strb;
        logic [31:0] mask;
        logic [31:0] exp;
        check_eq("idle_ready", req_ready, 1);
        check_eq("idle_busy", busy, 0);
        req_valid    = 1'b1;
        req_is_store = st;
        req_funct3   = f3;
        req_addr     = addr;
        req_wdata    = wdata;
        req_rd       = rd;
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_rd    = 5'($urandom);
`ifdef LSU_MISALIGN_TRAP_EN
        if (model_misaligned(st, f3, addr)) begin
            check_eq("trap_mem_valid", mem_valid, 0);
            check_eq("trap_err", err, 1);
            check_eq("trap_wb_we", wb_we, 0);
            @(negedge clk);
            check_eq("trap_err_clear", err, 0);
            check_eq("trap_busy", busy, 0);
            check_eq("trap_mem_valid2", mem_valid, 0);
            return;
        end
`endif
        strb = st ? model_strb(f3, addr) : 4'b0000;
        mask = strb_mask(strb);
        for (int k = 0; k <= rdly; k++) begin
            check_eq("req_mem_valid", mem_valid, 1);
            check_eq("req_ready_low", req_ready, 0);
            check_eq("req_mem_addr", mem_addr, addr & 32'hffff_fffc);
            check_eq("req_mem_wstrb", mem_wstrb, strb);
            check_eq("req_mem_wdata", mem_wdata & mask, model_lanes(f3, addr, wdata) & mask);
            check_eq("req_wb_we", wb_we, 0);
            check_eq("req_err", err, 0);
            if (k == rdly) mem_ready = 1'b1;
            @(negedge clk);
        end
        mem_ready = 1'b0;
        if (st) begin
            check_eq("st_done_busy", busy, 0);
            check_eq("st_done_mem_valid", mem_valid, 0);
            check_eq("st_done_wb_we", wb_we, 0);
            return;
        end
        for (int k = 0; k <= vdly; k++) begin
            check_eq("wait_mem_valid", mem_valid, 0);
            check_eq("wait_busy", busy, 1);
            check_eq("wait_wb_we", wb_we, 0);
            if (k == vdly) begin
                mem_rvalid = 1'b1;
                mem_rdata  = rdata;
            end
            @(negedge clk);
        end
        mem_rvalid = 1'b0;
        mem_rdata  = $urandom;
        exp = model_load(f3, addr, rdata);
        check_eq("wb_we", wb_we, (rd != 5'd0));
        check_eq("wb_busy", busy, 1);
        if (rd != 5'd0) begin
            check_eq("wb_rd", wb_rd, rd);
            check_eq("wb_wdata", wb_wdata, exp);
        end
        @(negedge clk);
        check_eq("post_wb_we", wb_we, 0);
        check_eq("post_busy", busy, 0);
        if (rd != 5'd0) begin
            check_eq("hold_wb_rd", wb_rd, rd);
            check_eq("hold_wb_wdata", wb_wdata, exp);
        end
    endtask

    initial begin
        bit          st;
        logic [2:0]  f3;
        logic [4:0]  rd;

        reset_n      = 1'b0;
        req_valid    = 1'b0;
        req_is_store = 1'b0;
        req_funct3   = 3'b000;
        req_addr     = 32'h0;
        req_wdata    = 32'h0;
        req_rd       = 5'd0;
        mem_ready    = 1'b0;
        mem_rvalid   = 1'b0;
        mem_rdata    = 32'h0;
        repeat (3) @(negedge clk);
        check_eq("rst_mem_valid", mem_valid, 0);
        check_eq("rst_wb_we", wb_we, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_mem_addr", mem_addr, 0);
        check_eq("rst_mem_wstrb", mem_wstrb, 0);
        check_eq("rst_mem_wdata", mem_wdata, 0);
        check_eq("rst_wb_rd", wb_rd, 0);
        check_eq("rst_wb_wdata", wb_wdata, 0);
        reset_n = 1'b1;

        // Stray response right after reset must be ignored.
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1234_5678;
        @(negedge clk);
        mem_rvalid = 1'b0;
        check_eq("stray_wb_we", wb_we, 0);
        check_eq("stray_busy", busy, 0);
        check_eq("stray_ready", req_ready, 1);

        do_op(1'b0, F3_W,  32'h0000_0100, 32'h0, 5'd5, 0, 0, 32'hDEAD_BEEF);
        check_eq("lw_literal", wb_wdata, 32'hDEAD_BEEF);
        do_op(1'b0, F3_B,  32'h0000_0103, 32'h0, 5'd6, 0, 0, 32'h8011_2233);
        check_eq("lb_literal", wb_wdata, 32'hFFFF_FF80);
        do_op(1'b0, F3_BU, 32'h0000_0103, 32'h0, 5'd6, 1, 2, 32'h8011_2233);
        check_eq("lbu_literal", wb_wdata, 32'h0000_0080);
        do_op(1'b0, F3_HU, 32'h0000_0102, 32'h0, 5'd7, 0, 1, 32'h8011_2233);
        check_eq("lhu_literal", wb_wdata, 32'h0000_8011);
        do_op(1'b1, F3_B,  32'h0000_0101, 32'h0000_00AB, 5'd3, 3, 0, 32'h0);
        do_op(1'b0, F3_W,  32'h0000_0100, 32'h0, 5'd0, 0, 0, 32'hCAFE_F00D);
        do_op(1'b0, F3_W,  32'h0000_0102, 32'h0, 5'd9, 0, 0, 32'h0BAD_CAFE);

        // Reset while a request is pending on the memory port.
        req_valid    = 1'b1;
        req_is_store = 1'b0;
        req_funct3   = F3_W;
        req_addr     = 32'h0000_0200;
        req_rd       = 5'd7;
        @(negedge clk);
        req_valid = 1'b0;
        check_eq("abort_pre_valid", mem_valid, 1);
        reset_n = 1'b0;
        #1;
        check_eq("abort_mem_valid", mem_valid, 0);
        check_eq("abort_busy", busy, 0);
        check_eq("abort_wb_we", wb_we, 0);
        @(negedge clk);
        reset_n    = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h5555_AAAA;
        @(negedge clk);
        mem_rvalid = 1'b0;
        check_eq("abort_late_wb_we", wb_we, 0);
        check_eq("abort_late_busy", busy, 0);
        @(negedge clk);
        check_eq("abort_late_wb_we2", wb_we, 0);
        do_op(1'b0, F3_H, 32'h0000_0206, 32'h0, 5'd8, 0, 0, 32'h9ABC_1234);

        for (int n = 0; n < 60; n++) begin
            st = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            do_op(st, f3, $urandom, $urandom, rd, $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
